v_result_writeback: RTL and testbench

Result-side endpoint of the fixed-latency vector ALU pipelines. Accepts the `out_vec`/`out_valid`/`out_addr` stream of a unit such as the and/or/xor pipe, which has no backpressure, and buffers it in a small FIFO. It drains the FIFO to the vector register file write port under a valid/ready handshake. It also returns issue credits to the sequencer so the sequencer never launches an operation whose result could not be stored.

---
 rtl/vwb_pkg.sv | 18 +
 rtl/v_wb_fifo.sv | 65 ++++++
 rtl/v_result_writeback.sv | 100 ++++++++++
 tb/tb_v_result_writeback.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vwb_pkg.sv
// Shared constants and entry layout for the vector result writeback block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vwb_pkg;

    localparam int VWB_DATA_W = 64;
    localparam int VWB_ADDR_W = 32;
    localparam int VWB_DEPTH  = 8;

    // One buffered result: address in the upper bits, data in the lower bits.
    typedef struct packed {
        logic [VWB_ADDR_W-1:0] addr;
        logic [VWB_DATA_W-1:0] data;
    } vwb_entry_t;

    localparam int VWB_ENTRY_W = $bits(vwb_entry_t);

endpackage

// File: rtl/v_wb_fifo.sv
// Synchronous result FIFO with count, full/empty and flop-driven head data.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none internally; the caller must not push when full without popping, nor pop when empty.
module v_wb_fifo
    import vwb_pkg::*;
#(
    parameter int WIDTH = VWB_ENTRY_W,
    parameter int DEPTH = VWB_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // State registers; storage is cleared on reset so the head reads zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/v_result_writeback.sv
// Buffers ALU results (no backpressure) and drains them to the VRF, returning issue credits.
// Latency: in_valid at N -> wb_valid at N+1; same cycle when VWB_BYPASS_EN is defined and the FIFO is empty.
// Backpressure: wb_valid/wb_ready toward the VRF; issue_ready credits toward the sequencer.
module v_result_writeback
    import vwb_pkg::*;
#(
    parameter int RESP_DATA_WIDTH = VWB_DATA_W,
    parameter int REQ_ADDR_WIDTH  = VWB_ADDR_W,
    parameter int FIFO_DEPTH      = VWB_DEPTH,
    parameter int CNT_WIDTH       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_fire,
    output logic                       issue_ready,
    input  logic [RESP_DATA_WIDTH-1:0] in_vec,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    input  logic                       in_valid,
    output logic [RESP_DATA_WIDTH-1:0] wb_data,
    output logic [REQ_ADDR_WIDTH-1:0]  wb_addr,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [CNT_WIDTH-1:0]       occupancy,
    output logic                       err_ovf
);

    localparam int EW = REQ_ADDR_WIDTH + RESP_DATA_WIDTH;

    logic [EW-1:0]        fifo_dout;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_WIDTH-1:0] fifo_count;
    logic                 byp_active, byp_take;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 err_ovf_q, err_ovf_d;

    v_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({in_addr, in_vec}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef VWB_BYPASS_EN
    // An arriving result skips the empty FIFO and is offered to the VRF in the same cycle.
    assign byp_active = fifo_empty & in_valid;
`else
    assign byp_active = 1'b0;
`endif
    assign byp_take = byp_active & wb_ready;

    // Write port mux, FIFO control and overflow detection.
    always_comb begin
        wb_valid  = ~fifo_empty | byp_active;
        wb_addr   = fifo_dout[EW-1:RESP_DATA_WIDTH];
        wb_data   = fifo_dout[RESP_DATA_WIDTH-1:0];
        if (byp_active) begin
            wb_addr = in_addr;
            wb_data = in_vec;
        end
        fifo_pop  = ~fifo_empty & wb_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        fifo_push = in_valid & ~byp_take & (~fifo_full | fifo_pop);
        err_ovf_d = err_ovf_q | (in_valid & fifo_full & ~fifo_pop);
    end

    // In-flight credit count: issue adds, result arrival removes, saturating at both ends.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_fire, in_valid})
            2'b10:   if (inflight_q != '1) inflight_d = inflight_q + CNT_WIDTH'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CNT_WIDTH'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Credit and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign issue_ready = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_WIDTH + 1)'(FIFO_DEPTH);
    assign occupancy   = fifo_count;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_v_result_writeback.sv
// Randomized and directed bench for v_result_writeback against a queue-based reference model.
// Latency: inputs driven at the falling edge, outputs compared 1 ns later.
// Backpressure: wb_ready and issue/result traffic randomized; sequencer honours the model's credit rule.
module tb_v_result_writeback;

`ifdef VWB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_fire, issue_ready;
    logic [63:0] in_vec, wb_data;
    logic [31:0] in_addr, wb_addr;
    logic        in_valid, wb_valid, wb_ready;
    logic [3:0]  occupancy;
    logic        err_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state: ordered buffer contents, outstanding issues, sticky overflow.
    logic [95:0] mq[$];
    int          m_infl;
    bit          m_err;

    v_result_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .issue_fire  (issue_fire),
        .issue_ready (issue_ready),
        .in_vec      (in_vec),
        .in_addr     (in_addr),
        .in_valid    (in_valid),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .occupancy   (occupancy),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; issue_fire = 0; in_valid = 0; wb_ready = 0; in_vec = '0; in_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_infl = 0; m_err = 0;
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_err_ovf", err_ovf, 0);
        @(negedge clk);
    endtask

    // One cycle: drive, compare against model, advance model, wait for next falling edge.
    task automatic step(input bit f, input bit iv, input bit rd, input logic [63:0] d, input logic [31:0] a);
        bit          ev;
        logic [63:0] ed;
        logic [31:0] ea;
        issue_fire = f; in_valid = iv; wb_ready = rd; in_vec = d; in_addr = a;
        #1;
        ev = (mq.size() > 0) || (BYP && iv);
        if (mq.size() > 0) {ea, ed} = mq[0];
        else               {ea, ed} = {a, d};
        chk("wb_valid", wb_valid, ev);
        if (ev) begin
            chk("wb_data", wb_data, ed);
            chk("wb_addr", wb_addr, ea);
        end
        chk("issue_ready", issue_ready, (mq.size() + m_infl) < DEPTH);
        chk("occupancy", occupancy, mq.size());
        chk("err_ovf", err_ovf, m_err);
        if (!(BYP && mq.size() == 0 && iv && rd)) begin
            if (ev && rd) void'(mq.pop_front());
            if (iv) begin
                if (mq.size() < DEPTH) mq.push_back({a, d});
                else                   m_err = 1;
            end
        end
        if (f && !iv)                     m_infl++;
        else if (iv && !f && m_infl > 0) m_infl--;
        @(negedge clk);
    endtask

    task automatic rstep(input int pf, input int piv, input int prd);
        bit f;
        f = ((mq.size() + m_infl) < DEPTH) && ($urandom_range(99) < pf);
        step(f, $urandom_range(99) < piv, $urandom_range(99) < prd,
             {$urandom, $urandom}, $urandom);
    endtask

    initial begin
        do_reset();

        // Single result through the pipe.
        step(1, 0, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 64'hA5A5, 32'h10);
        repeat (3) step(0, 0, 1, 0, 0);

        // Credit exhaustion, full push+pop, forced overflow, stalled drain.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 64'(i) * 64'h1111, 32'(i));
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 64'h9999, 32'h9);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 64'hDEAD, 32'hBAD);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, (i % 3) == 0, 0, 0);

        // Reset mid-stream with 5 buffered and 2 outstanding.
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, {$urandom, $urandom}, $urandom);
        chk("pre_rst_occupancy", occupancy, 5);
        do_reset();

        // Random traffic at several load points.
        for (int i = 0; i < 1500; i++) rstep(60, 50, 70);
        for (int i = 0; i < 1500; i++) rstep(80, 70, 20);
        do_reset();
        for (int i = 0; i < 1500; i++) rstep(50, 40, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
